frisc_lsu: RTL and testbench

Load/store unit for the frisc core: the initiator side of the byte-addressable data memory. Accepts one load or store request at a time from the execute stage, drives the memory's address, write data and per-byte write mask, and sign- or zero-extends sub-word load data. Sits between the execute stage and the data memory; the memory returns the 4 bytes at `addr .. addr+3` combinationally and writes masked bytes on the clock edge.

---
 rtl/frisc_lsu_pkg.sv | 47 ++++
 rtl/frisc_lsu_load_align.sv | 24 ++
 rtl/frisc_lsu.sv | 93 +++++++++
 tb/tb_frisc_lsu.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frisc_lsu_pkg.sv
// Shared definitions for the frisc load/store unit: funct3 codes, FSM states, mask and legality helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package frisc_lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_RESP
    } lsu_state_t;

    function automatic logic [3:0] store_mask(input logic [2:0] funct3);
        case (funct3)
            SB:      store_mask = 4'b0001;
            SH:      store_mask = 4'b0011;
            SW:      store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
        if (store)
            funct3_illegal = (funct3 > SW);
        else
            funct3_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    // Load and store encodings coincide for half/word, so one check covers both.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        if ((funct3 == LH) || (funct3 == LHU))
            misaligned = addr_lo[0];
        else if (funct3 == LW)
            misaligned = (addr_lo != 2'b00);
        else
            misaligned = 1'b0;
    endfunction

endpackage

// File: rtl/frisc_lsu_load_align.sv
// Sign/zero extension of 32-bit raw load data selected by funct3.
// Latency: combinational.
// Backpressure: none.
module frisc_lsu_load_align
    import frisc_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = 32'h0;
        case (funct3)
            LB:      data = {{24{raw[7]}}, raw[7:0]};
            LBU:     data = {24'h0, raw[7:0]};
            LH:      data = {{16{raw[15]}}, raw[15:0]};
            LHU:     data = {16'h0, raw[15:0]};
            LW:      data = raw;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/frisc_lsu.sv
// Load/store unit: one request at a time, IDLE -> MEM -> RESP; FRISC_LSU_MISALIGN_TRAP_EN makes misaligned accesses fault.
// Latency: legal request responds 2 cycles after acceptance, faulting request 1 cycle after.
// Backpressure: req_ready only in IDLE; response held in RESP until resp_ready.
module frisc_lsu
    import frisc_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    output logic [3:0]            mem_write_mask,
    input  logic [31:0]           mem_read_data
);

    lsu_state_t  state;
    logic        st_store;
    logic [2:0]  st_funct3;
    logic        req_bad;
    logic [31:0] ld_data;

    always_comb begin
`ifdef FRISC_LSU_MISALIGN_TRAP_EN
        req_bad = funct3_illegal(req_store, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
        req_bad = funct3_illegal(req_store, req_funct3);
`endif
    end

    frisc_lsu_load_align u_load_align (
        .funct3 (st_funct3),
        .raw    (mem_read_data),
        .data   (ld_data)
    );

    assign req_ready      = (state == ST_IDLE) && !reset;
    assign resp_valid     = (state == ST_RESP);
    // Gated by reset so a reset landing in the MEM cycle suppresses the write.
    assign mem_write_mask = ((state == ST_MEM) && st_store && !reset) ? store_mask(st_funct3) : 4'b0000;

    // mem_addr / mem_write_data double as the latched request address and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            st_store       <= 1'b0;
            st_funct3      <= 3'b000;
            resp_rdata     <= 32'h0;
            resp_fault     <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        st_store   <= req_store;
                        st_funct3  <= req_funct3;
                        resp_rdata <= 32'h0;
                        if (req_bad) begin
                            resp_fault <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            resp_fault     <= 1'b0;
                            mem_addr       <= req_addr;
                            mem_write_data <= req_wdata;
                            state          <= ST_MEM;
                        end
                    end
                end
                ST_MEM: begin
                    resp_rdata <= st_store ? 32'h0 : ld_data;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frisc_lsu.sv
// Directed self-checking bench for frisc_lsu with a byte-array memory model.
module tb_frisc_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_mask;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;
    int mask_cycles = 0;
    logic [3:0] last_mask = 4'b0000;

    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic [7:0] a0, a1, a2, a3;

    // Reference extension unit, exercised directly against hand-computed values.
    logic [2:0]  ref_f3;
    logic [31:0] ref_raw;
    logic [31:0] ref_out;

    always #5 clk = ~clk;

    frisc_lsu #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_mask (mem_write_mask),
        .mem_read_data  (mem_read_data)
    );

    frisc_lsu_load_align u_ref (
        .funct3 (ref_f3),
        .raw    (ref_raw),
        .data   (ref_out)
    );

    assign a0 = mem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign mem_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};

    always @(posedge clk) begin
        if (mem_write_mask[0]) mem[a0] <= mem_write_data[7:0];
        if (mem_write_mask[1]) mem[a1] <= mem_write_data[15:8];
        if (mem_write_mask[2]) mem[a2] <= mem_write_data[23:16];
        if (mem_write_mask[3]) mem[a3] <= mem_write_data[31:24];
    end

    always @(negedge clk) begin
        if (mem_write_mask != 4'b0000) begin
            mask_cycles <= mask_cycles + 1;
            last_mask   <= mem_write_mask;
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        rd  = 32'h0;
        flt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) begin
            errors++;
            $display("FAIL timeout resp_valid never rose for addr %h", a);
            lat = -1;
        end else begin
            rd  = resp_rdata;
            flt = resp_fault;
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_in_reset got %b want 0", req_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++;
        if ({resp_valid, resp_fault, mem_write_mask} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b%b%b want 000000", resp_valid, resp_fault, mem_write_mask);
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_write_data} !== 96'h0) begin
            errors++; $display("FAIL reset_regs got %h %h %h want 0 0 0", resp_rdata, mem_addr, mem_write_data);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic flt; int lat; int m0;
        m0 = mask_cycles;
        do_req(1'b1, 3'b010, 32'h4, 32'hDEADBEEF, rd, flt, lat);
        checks++;
        if ({flt, rd} !== 33'h0) begin errors++; $display("FAIL sw_resp got fault %b rdata %h want 0 0", flt, rd); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
        checks++;
        if ((mask_cycles - m0) !== 1 || last_mask !== 4'b1111) begin
            errors++; $display("FAIL sw_mask got %0d cycles mask %b want 1 cycle 1111", mask_cycles - m0, last_mask);
        end
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin errors++; $display("FAIL lw_data got %h fault %b want deadbeef 0", rd, flt); end
    endtask

    task automatic test_extend;
        logic [31:0] rd; logic flt; int lat;
        do_req(1'b1, 3'b000, 32'h9, 32'h00000080, rd, flt, lat);
        do_req(1'b1, 3'b001, 32'hA, 32'h00009234, rd, flt, lat);
        do_req(1'b0, 3'b000, 32'h9, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h want ffffff80", rd); end
        do_req(1'b0, 3'b100, 32'h9, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", rd); end
        do_req(1'b0, 3'b001, 32'hA, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'hFFFF9234) begin errors++; $display("FAIL lh got %h want ffff9234", rd); end
        do_req(1'b0, 3'b101, 32'hA, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'h00009234) begin errors++; $display("FAIL lhu got %h want 00009234", rd); end
        ref_raw = 32'h12345678; ref_f3 = 3'b010; #1;
        checks++;
        if (ref_out !== 32'h12345678) begin errors++; $display("FAIL align_lw got %h want 12345678", ref_out); end
        ref_raw = 32'h0000_7F80; ref_f3 = 3'b001; #1;
        checks++;
        if (ref_out !== 32'h00007F80) begin errors++; $display("FAIL align_lh_pos got %h want 00007f80", ref_out); end
        ref_f3 = 3'b011; #1;
        checks++;
        if (ref_out !== 32'h0) begin errors++; $display("FAIL align_illegal got %h want 0", ref_out); end
    endtask

    task automatic test_sb_merge;
        logic [31:0] rd; logic flt; int lat; int m0;
        do_req(1'b1, 3'b010, 32'h4, 32'h11223344, rd, flt, lat);
        m0 = mask_cycles;
        do_req(1'b1, 3'b000, 32'h5, 32'h000000AA, rd, flt, lat);
        checks++;
        if ((mask_cycles - m0) !== 1 || last_mask !== 4'b0001) begin
            errors++; $display("FAIL sb_mask got %0d cycles mask %b want 1 cycle 0001", mask_cycles - m0, last_mask);
        end
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'h1122AA44) begin errors++; $display("FAIL sb_merge got %h want 1122aa44", rd); end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic flt; int lat; int m0;
        m0 = mask_cycles;
        do_req(1'b0, 3'b011, 32'h4, 32'h0, rd, flt, lat);
        checks++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            errors++; $display("FAIL illegal_load got fault %b rdata %h lat %0d want 1 0 1", flt, rd, lat);
        end
        do_req(1'b1, 3'b011, 32'h4, 32'hFFFFFFFF, rd, flt, lat);
        checks++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            errors++; $display("FAIL illegal_store got fault %b rdata %h lat %0d want 1 0 1", flt, rd, lat);
        end
        do_req(1'b1, 3'b100, 32'h4, 32'hFFFFFFFF, rd, flt, lat);
        checks++;
        if (flt !== 1'b1 || lat !== 1) begin errors++; $display("FAIL illegal_store100 got fault %b lat %0d want 1 1", flt, lat); end
        checks++;
        if ((mask_cycles - m0) !== 0) begin errors++; $display("FAIL illegal_no_write got %0d want 0", mask_cycles - m0); end
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'h1122AA44) begin errors++; $display("FAIL illegal_mem_intact got %h want 1122aa44", rd); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b100; req_addr = 32'h9; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_funct3 = 3'b010; req_addr = 32'h4;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_mem got %b want 0", req_ready); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000080) begin
            errors++; $display("FAIL bp_first got valid %b rdata %h want 1 00000080", resp_valid, resp_rdata);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000080 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got valid %b rdata %h ready %b want 1 00000080 0",
                                   i, resp_valid, resp_rdata, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid %b ready %b want 0 1", resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_second_mem got valid %b ready %b want 0 0", resp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122AA44) begin
            errors++; $display("FAIL bp_second got valid %b rdata %h want 1 1122aa44", resp_valid, resp_rdata);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic flt; int lat;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_write_mask !== 4'b1111) begin errors++; $display("FAIL rst_pre_mask got %b want 1111", mem_write_mask); end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write_mask !== 4'b0000) begin errors++; $display("FAIL rst_gated_mask got %b want 0000", mem_write_mask); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_idle got valid %b ready %b want 0 1", resp_valid, req_ready);
        end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, flt, lat);
        checks++;
        if (rd !== 32'h0 || flt !== 1'b0) begin errors++; $display("FAIL rst_no_write got %h fault %b want 0 0", rd, flt); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic flt; int lat;
        do_req(1'b0, 3'b010, 32'h6, 32'h0, rd, flt, lat);
`ifdef FRISC_LSU_MISALIGN_TRAP_EN
        checks++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            errors++; $display("FAIL misalign_lw got fault %b rdata %h lat %0d want 1 0 1", flt, rd, lat);
        end
`else
        checks++;
        if (flt !== 1'b0 || rd !== 32'h80001122 || lat !== 2) begin
            errors++; $display("FAIL misalign_lw got fault %b rdata %h lat %0d want 0 80001122 2", flt, rd, lat);
        end
`endif
        do_req(1'b0, 3'b101, 32'hB, 32'h0, rd, flt, lat);
`ifdef FRISC_LSU_MISALIGN_TRAP_EN
        checks++;
        if (flt !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_lhu got fault %b rdata %h want 1 0", flt, rd); end
`else
        checks++;
        if (flt !== 1'b0 || rd !== 32'h00000092) begin errors++; $display("FAIL misalign_lhu got fault %b rdata %h want 0 00000092", flt, rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extend();
        test_sb_merge();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
